router_ingress: RTL
===================

Name: router_ingress

Overview:
- Input stage of the 1x3 router. Accepts byte-serial packets from the source, decodes the destination from the header, and steers bytes into one of three downstream byte FIFOs.
- Generates the FIFO write strobes and the first-byte marker (lfd_state). Applies back-pressure (busy) while the target FIFO is occupied or full.
- Computes running XOR parity and flags parity or length errors at end of packet.
- Packet format: header [7:2]=payload length L, [1:0]=address (0..2; 3 is invalid), then L payload bytes with pkt_valid=1, then one parity byte with pkt_valid=0.

Parameters:
DW, 8, data byte width
LEN_W, 6, header length field width (DW-2)

Ports:
clock  in  1  system clock
resetn  in  1  synchronous, active-low reset
pkt_valid  in  1  source: header/payload byte valid
data_in  in  DW  source byte
fifo_full  in  3  per-FIFO full
fifo_empty  in  3  per-FIFO empty
soft_reset  in  3  per-FIFO flush request
busy  out  1  source must hold data_in/pkt_valid while high
write_enb  out  3  one-hot FIFO write strobe
dout  out  DW  byte to FIFOs
lfd_state  out  1  high exactly one cycle before the header write
err  out  1  parity/length error of last packet, sticky until next header accepted
parity_done  out  1  one-cycle pulse at end of packet

Behaviour:
- Reset (resetn=0, synchronous): state=DECODE; busy=0, write_enb=0, lfd_state=0, err=0, parity_done=0. Internal hold, addr, cnt and parity registers cleared. dout is don't-care while write_enb=0.
- DECODE: busy=0.
  - If pkt_valid and data_in[1:0]!=3: latch hold=data_in, addr, cnt=L, calc_par=data_in; clear err.
  - Next state is LOAD_HDR if fifo_empty[addr], else WAIT_EMPTY.
  - Header with address 3: dropped; stay in DECODE; no writes.
- WAIT_EMPTY: busy=1. Move to LOAD_HDR when fifo_empty[addr].
- lfd_state = (next_state==LOAD_HDR), combinational. The FIFO registers it internally, so it pairs with the header write on the following cycle.
- LOAD_HDR: write_enb[addr]=1, dout=hold, busy=1; then go to LOAD_DATA. The header write cannot hit a full FIFO because the FIFO was empty on entry.
- LOAD_DATA: dout=data_in.
  - If fifo_full[addr]: busy=1, write_enb=0, byte not consumed, stay.
  - Else if pkt_valid: write_enb[addr]=1, calc_par^=data_in, cnt-=1. If cnt is already 0, set len_err and do not decrement (saturate).
  - Else (parity byte): write_enb[addr]=1, latch rx_par=data_in; go to CHECK.
  - busy=0 whenever not full.
- CHECK: busy=1, no write. Registered err <= (rx_par!=calc_par) | len_err | (cnt!=0). Pulse parity_done for 1 cycle; go to DECODE.
- Accepted bytes per packet = L+2 writes: header, L payload bytes, parity. Only the addressed write_enb bit may be asserted.
- soft_reset[addr] while state!=DECODE: next state is DECODE, no write that cycle, err unchanged, parity_done=0. soft_reset on non-addressed ports is ignored.
- Simultaneous fifo_full and pkt_valid=0 in LOAD_DATA: the parity byte is held until not full.
- resetn dominates soft_reset.

Decomposition:
- Shared package router_pkg: state enum (DECODE, WAIT_EMPTY, LOAD_HDR, LOAD_DATA, CHECK), ADDR_INVALID=2'b11, header field slice constants, NUM_PORTS=3.
- One sub-module, router_parity_acc: accumulator with clear/load/xor-enable, compare output. All else stays in a single module.

Test Plan:
- Header 0x0C (addr0, L=3), payload 11,22,33, parity 0x0C, FIFO0 empty -> lfd_state 1 cycle, then write_enb=001 for 5 cycles carrying 0C,11,22,33,0C; parity_done pulse; err=0.
- Same packet with parity 0x0D -> identical writes; err=1 after CHECK; next valid header clears err.
- Header 0x0F (addr3) -> no write_enb, busy=0, state stays DECODE. Then header 0x04 (addr0, L=1), payload AA, parity AE -> normal delivery.
- Header 0x05 (addr1, L=1) with fifo_empty[1]=0 for 4 cycles -> busy=1, write_enb=0 throughout; header write 1 cycle after empty rises, lfd_state in that empty cycle.
- Addr2 L=4; fifo_full[2]=1 during the 2nd payload byte for 3 cycles -> busy=1, write_enb=000, data held; resumes with no loss or duplication, 6 writes total.
- Addr0 L=5; soft_reset[0] after 2 payload bytes -> DECODE next cycle, busy=0, no further writes. Also: L=2 sent with 3 payload bytes -> err=1.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: port count, header field layout and
// ingress FSM state encodings.
package router_pkg;
  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;
  localparam int HDR_LEN_LSB = ADDR_W;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  localparam logic [2:0] S_DECODE     = 3'd0;
  localparam logic [2:0] S_WAIT_EMPTY = 3'd1;
  localparam logic [2:0] S_LOAD_HDR   = 3'd2;
  localparam logic [2:0] S_LOAD_DATA  = 3'd3;
  localparam logic [2:0] S_CHECK      = 3'd4;
endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity over header and payload bytes.
// Also compares the running value against the received parity byte.
module router_parity_acc #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          xor_en_i,
  input  logic [DW-1:0] load_val_i,
  input  logic [DW-1:0] xor_val_i,
  input  logic [DW-1:0] cmp_i,
  output logic          mismatch_o
);
  logic [DW-1:0] acc_q;

  always_ff @(posedge clock) begin
    if (!resetn || clr_i)  acc_q <= '0;
    else if (load_i)       acc_q <= load_val_i;
    else if (xor_en_i)     acc_q <= acc_q ^ xor_val_i;
  end

  assign mismatch_o = (acc_q != cmp_i);
endmodule

// File: rtl/router_ingress.sv
// Router input stage: decodes the header, steers bytes to one of three FIFOs,
// back-pressures the source and checks parity/length at end of packet.
module router_ingress
  import router_pkg::*;
#(
  parameter int DW    = 8,
  parameter int LEN_W = DW - 2
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          pkt_valid,
  input  logic [DW-1:0] data_in,
  input  logic [2:0]    fifo_full,
  input  logic [2:0]    fifo_empty,
  input  logic [2:0]    soft_reset,
  output logic          busy,
  output logic [2:0]    write_enb,
  output logic [DW-1:0] dout,
  output logic          lfd_state,
  output logic          err,
  output logic          parity_done
);
  logic [2:0]        state_q, state_d;
  logic [DW-1:0]     hold_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DW-1:0]     rx_par_q;
  logic              len_err_q;
  logic              err_q;

  // Padded to 4 entries so any 2-bit address indexes in range.
  logic [3:0] empty4, full4, srst4;
  assign empty4 = {1'b0, fifo_empty};
  assign full4  = {1'b0, fifo_full};
  assign srst4  = {1'b0, soft_reset};

  logic [ADDR_W-1:0] hdr_addr;
  logic              hdr_ok, abort, take_pl, take_par, par_mismatch;
  logic [2:0]        sel;

  assign hdr_addr = data_in[ADDR_W-1:0];
  assign hdr_ok   = pkt_valid && (hdr_addr != ADDR_INVALID);
  assign abort    = (state_q != S_DECODE) && srst4[addr_q];
  assign sel      = 3'b001 << addr_q;
  assign take_pl  = (state_q == S_LOAD_DATA) && !full4[addr_q] && pkt_valid && !abort;
  assign take_par = (state_q == S_LOAD_DATA) && !full4[addr_q] && !pkt_valid && !abort;

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    write_enb   = '0;
    parity_done = 1'b0;
    case (state_q)
      S_DECODE: begin
        if (hdr_ok) state_d = empty4[hdr_addr] ? S_LOAD_HDR : S_WAIT_EMPTY;
      end
      S_WAIT_EMPTY: begin
        busy = 1'b1;
        if (empty4[addr_q]) state_d = S_LOAD_HDR;
      end
      S_LOAD_HDR: begin
        busy      = 1'b1;
        write_enb = sel;
        state_d   = S_LOAD_DATA;
      end
      S_LOAD_DATA: begin
        if (full4[addr_q]) begin
          busy = 1'b1;
        end else begin
          write_enb = sel;
          if (!pkt_valid) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy        = 1'b1;
        parity_done = 1'b1;
        state_d     = S_DECODE;
      end
      default: state_d = S_DECODE;
    endcase
    // A flush of the addressed FIFO abandons the packet mid-flight.
    if (abort) begin
      state_d     = S_DECODE;
      write_enb   = '0;
      parity_done = 1'b0;
    end
  end

  assign lfd_state = (state_d == S_LOAD_HDR);
  assign dout      = (state_q == S_LOAD_HDR) ? hold_q : data_in;
  assign err       = err_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_DECODE;
      hold_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      rx_par_q  <= '0;
      len_err_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && hdr_ok) begin
        hold_q    <= data_in;
        addr_q    <= hdr_addr;
        cnt_q     <= data_in[DW-1:HDR_LEN_LSB];
        len_err_q <= 1'b0;
        err_q     <= 1'b0;
      end
      // Count saturates at zero; extra payload bytes flag a length error.
      if (take_pl) begin
        if (cnt_q == '0) len_err_q <= 1'b1;
        else             cnt_q     <= cnt_q - 1'b1;
      end
      if (take_par) rx_par_q <= data_in;
      if (state_q == S_CHECK && !abort)
        err_q <= par_mismatch | len_err_q | (cnt_q != '0);
    end
  end

  router_parity_acc #(.DW(DW)) u_par (
    .clock      (clock),
    .resetn     (resetn),
    .clr_i      (abort),
    .load_i     (state_q == S_DECODE && hdr_ok),
    .xor_en_i   (take_pl),
    .load_val_i (data_in),
    .xor_val_i  (data_in),
    .cmp_i      (rx_par_q),
    .mismatch_o (par_mismatch)
  );
endmodule
